// File: rtl/leaf_cluster_if.sv
// Cluster of NUM_LEAF BFT leaf channels: per-channel ingress FIFO and egress resend register.
// Optional drop counters are built when LEAF_CLUSTER_DROP_CNT_EN is defined.
module leaf_cluster_if #(
    parameter int                  NUM_LEAF   = 4,
    parameter int                  PKT_W      = 49,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [NUM_LEAF-1:0] LEAF_MASK  = 4'b0111,
    parameter int                  CNT_W      = 16
) (
    input  logic                          clk_400,
    input  logic                          reset_400,
    input  logic [NUM_LEAF*PKT_W-1:0]     din_leaf_bft2interface,
    output logic [NUM_LEAF*PKT_W-1:0]     dout_leaf_interface2bft,
    input  logic [NUM_LEAF-1:0]           resend,
    input  logic [NUM_LEAF-1:0]           ap_start,
    output logic [NUM_LEAF*(PKT_W-1)-1:0] rx_data,
    output logic [NUM_LEAF-1:0]           rx_valid,
    input  logic [NUM_LEAF-1:0]           rx_ready,
    input  logic [NUM_LEAF*(PKT_W-1)-1:0] tx_data,
    input  logic [NUM_LEAF-1:0]           tx_valid,
    output logic [NUM_LEAF-1:0]           tx_ready,
    output logic [NUM_LEAF*CNT_W-1:0]     drop_cnt
);

    localparam int PAY_W = PKT_W - 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

`ifdef LEAF_CLUSTER_DROP_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    for (genvar g = 0; g < NUM_LEAF; g++) begin : g_ch
`ifdef LEAF_CLUSTER_DROP_CNT_EN
        logic w_drop;
`endif
        if (LEAF_MASK[g]) begin : g_pop
            typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

            logic [PAY_W-1:0] r_mem [FIFO_DEPTH];
            logic [PTR_W-1:0] r_wr_ptr;
            logic [PTR_W-1:0] r_rd_ptr;
            logic [OCC_W-1:0] r_occ;
            state_t           r_state;
            logic [PKT_W-1:0] r_out_q;
            logic             w_push;
            logic             w_pop;
            logic             w_full;
            logic             w_wr;
            logic             w_out_vld;

            assign w_push = din_leaf_bft2interface[g*PKT_W + PKT_W-1];
            assign w_full = (r_occ == OCC_W'(FIFO_DEPTH));
            assign w_pop  = (r_occ != '0) & rx_ready[g];
            // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
            assign w_wr   = w_push & (~w_full | w_pop);

            always_ff @(posedge clk_400 or negedge reset_400) begin
                if (!reset_400) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_occ    <= '0;
                end else begin
                    if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_occ <= r_occ + OCC_W'(w_wr) - OCC_W'(w_pop);
                end
            end

            always_ff @(posedge clk_400) begin
                if (w_wr) r_mem[r_wr_ptr] <= din_leaf_bft2interface[g*PKT_W +: PAY_W];
            end

            assign rx_valid[g]               = (r_occ != '0);
            assign rx_data[g*PAY_W +: PAY_W] = r_mem[r_rd_ptr];

            assign w_out_vld   = (r_state != IDLE);
            assign tx_ready[g] = reset_400 & ap_start[g] & ~(w_out_vld & resend[g]);

            // Egress: resend of a live packet wins over new data, otherwise fall back to idle.
            always_ff @(posedge clk_400 or negedge reset_400) begin
                if (!reset_400) begin
                    r_state <= IDLE;
                    r_out_q <= '0;
                end else if (w_out_vld && resend[g]) begin
                    r_state <= HOLD;
                end else if (tx_valid[g] && tx_ready[g]) begin
                    r_state <= SEND;
                    r_out_q <= {1'b1, tx_data[g*PAY_W +: PAY_W]};
                end else begin
                    r_state <= IDLE;
                    r_out_q <= '0;
                end
            end

            assign dout_leaf_interface2bft[g*PKT_W +: PKT_W] = r_out_q;
`ifdef LEAF_CLUSTER_DROP_CNT_EN
            assign w_drop = w_push & w_full & ~w_pop;
`endif
        end else begin : g_stub
            logic w_unused_stub;

            assign dout_leaf_interface2bft[g*PKT_W +: PKT_W] = '0;
            assign rx_data[g*PAY_W +: PAY_W] = '0;
            assign rx_valid[g] = 1'b0;
            assign tx_ready[g] = 1'b0;
            assign w_unused_stub = ^{din_leaf_bft2interface[g*PKT_W +: PKT_W], resend[g],
                                     ap_start[g], rx_ready[g], tx_valid[g],
                                     tx_data[g*PAY_W +: PAY_W]};
`ifdef LEAF_CLUSTER_DROP_CNT_EN
            assign w_drop = din_leaf_bft2interface[g*PKT_W + PKT_W-1];
`endif
        end

`ifdef LEAF_CLUSTER_DROP_CNT_EN
        logic [CNT_W-1:0] r_drop_cnt;

        always_ff @(posedge clk_400 or negedge reset_400) begin
            if (!reset_400)  r_drop_cnt <= '0;
            else if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
        end

        assign drop_cnt[g*CNT_W +: CNT_W] = r_drop_cnt;
`endif
    end

`ifndef LEAF_CLUSTER_DROP_CNT_EN
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_leaf_cluster_if.sv
// Bench for leaf_cluster_if: table-driven FIFO vectors, directed egress/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_leaf_cluster_if;

    localparam int NL = 4;
    localparam int PW = 49;
    localparam int DW = 48;
    localparam int D  = 4;
    localparam int CW = 4;
    localparam logic [NL-1:0] MASK = 4'b0111;
`ifdef LEAF_CLUSTER_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic              clk_400 = 1'b0;
    logic              reset_400;
    logic [NL*PW-1:0]  din;
    logic [NL*PW-1:0]  dout;
    logic [NL-1:0]     resend;
    logic [NL-1:0]     ap_start;
    logic [NL*DW-1:0]  rx_data;
    logic [NL-1:0]     rx_valid;
    logic [NL-1:0]     rx_ready;
    logic [NL*DW-1:0]  tx_data;
    logic [NL-1:0]     tx_valid;
    logic [NL-1:0]     tx_ready;
    logic [NL*CW-1:0]  drop_cnt;

    leaf_cluster_if #(
        .NUM_LEAF(NL), .PKT_W(PW), .FIFO_DEPTH(D), .LEAF_MASK(MASK), .CNT_W(CW)
    ) dut (
        .clk_400(clk_400), .reset_400(reset_400),
        .din_leaf_bft2interface(din), .dout_leaf_interface2bft(dout),
        .resend(resend), .ap_start(ap_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .drop_cnt(drop_cnt)
    );

    always #5 clk_400 = ~clk_400;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: payload queues, presented egress word, raw drop tallies.
    logic [DW-1:0] mq [NL][$];
    logic [PW-1:0] mout [NL];
    int            mdrop [NL];

    typedef struct {
        logic          v;
        logic [DW-1:0] pl;
        logic          rdy;
        logic          exp_rv;
        logic [DW-1:0] exp_rd;
        int            exp_drop;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic v, input logic [DW-1:0] pl, input logic rdy,
                                input logic rv, input logic [DW-1:0] rd, input int dr);
        vec_t t;
        t.v = v; t.pl = pl; t.rdy = rdy; t.exp_rv = rv; t.exp_rd = rd; t.exp_drop = dr;
        return t;
    endfunction

    function automatic logic [63:0] drop_exp(input int raw);
        int mx;
        mx = (1 << CW) - 1;
        if (!DROP_EN) return 64'd0;
        return 64'(raw > mx ? mx : raw);
    endfunction

    task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s ch%0d @%0t: got 0x%0h, expected 0x%0h", name, ch, $time, act, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NL; c++) begin
            mq[c].delete();
            mout[c]  = '0;
            mdrop[c] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < NL; c++) begin
            logic rv, tr;
            rv = MASK[c] && (mq[c].size() > 0);
            tr = MASK[c] && ap_start[c] && !(mout[c][PW-1] && resend[c]);
            chk("rx_valid", c, 64'(rx_valid[c]), 64'(rv));
            if (rv) chk("rx_data", c, 64'(rx_data[c*DW +: DW]), 64'(mq[c][0]));
            chk("tx_ready", c, 64'(tx_ready[c]), 64'(tr));
            chk("dout", c, 64'(dout[c*PW +: PW]), 64'(mout[c]));
            chk("drop_cnt", c, 64'(drop_cnt[c*CW +: CW]), drop_exp(mdrop[c]));
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < NL; c++) begin
            logic v;
            logic [DW-1:0] pl;
            v  = din[c*PW + PW-1];
            pl = din[c*PW +: DW];
            if (!MASK[c]) begin
                if (v) mdrop[c]++;
            end else begin
                int  sz;
                logic pop;
                sz  = mq[c].size();
                pop = (sz > 0) && rx_ready[c];
                if (pop) void'(mq[c].pop_front());
                if (v) begin
                    if (sz < D || pop) mq[c].push_back(pl);
                    else mdrop[c]++;
                end
                if (mout[c][PW-1] && resend[c]) mout[c] = mout[c];
                else if (tx_valid[c] && ap_start[c]) mout[c] = {1'b1, tx_data[c*DW +: DW]};
                else mout[c] = '0;
            end
        end
    endtask

    task automatic eval_edge();
        check_outputs();
        model_update();
        @(posedge clk_400);
        #1;
    endtask

    task automatic tick();
        @(negedge clk_400);
        eval_edge();
    endtask

    task automatic clear_inputs();
        din = '0; resend = '0; ap_start = '0; rx_ready = '0; tx_data = '0; tx_valid = '0;
    endtask

    initial begin
        tbl[0]  = mk(1, 48'h1, 0, 0, 48'h0, 0);
        tbl[1]  = mk(1, 48'h2, 0, 1, 48'h1, 0);
        tbl[2]  = mk(1, 48'h3, 0, 1, 48'h1, 0);
        tbl[3]  = mk(1, 48'h4, 0, 1, 48'h1, 0);
        tbl[4]  = mk(1, 48'h5, 0, 1, 48'h1, 0);
        tbl[5]  = mk(1, 48'h6, 0, 1, 48'h1, 1);
        tbl[6]  = mk(0, 48'h0, 1, 1, 48'h1, 2);
        tbl[7]  = mk(0, 48'h0, 1, 1, 48'h2, 2);
        tbl[8]  = mk(0, 48'h0, 1, 1, 48'h3, 2);
        tbl[9]  = mk(0, 48'h0, 1, 1, 48'h4, 2);
        tbl[10] = mk(0, 48'h0, 0, 0, 48'h0, 2);
        tbl[11] = mk(1, 48'hA, 0, 0, 48'h0, 2);
        tbl[12] = mk(1, 48'hB, 0, 1, 48'hA, 2);
        tbl[13] = mk(1, 48'hC, 0, 1, 48'hA, 2);
        tbl[14] = mk(1, 48'hD, 0, 1, 48'hA, 2);
        tbl[15] = mk(1, 48'hE, 1, 1, 48'hA, 2);
        tbl[16] = mk(0, 48'h0, 1, 1, 48'hB, 2);
        tbl[17] = mk(0, 48'h0, 1, 1, 48'hC, 2);
        tbl[18] = mk(0, 48'h0, 1, 1, 48'hD, 2);
        tbl[19] = mk(0, 48'h0, 1, 1, 48'hE, 2);
        tbl[20] = mk(0, 48'h0, 0, 0, 48'h0, 2);

        // Reset then idle
        clear_inputs();
        reset_400 = 1'b0;
        ap_start  = 4'b0111;
        repeat (3) @(posedge clk_400);
        #1;
        chk("rst_dout", 0, 64'(|dout), 64'd0);
        chk("rst_rx_valid", 0, 64'(rx_valid), 64'd0);
        chk("rst_tx_ready", 0, 64'(tx_ready), 64'd0);
        chk("rst_drop_cnt", 0, 64'(drop_cnt), 64'd0);
        ap_start  = '0;
        reset_400 = 1'b1;
        model_reset();
        tick();
        ap_start = 4'b0111;
        #1;
        chk("tx_ready_same_cycle", 0, 64'(tx_ready), 64'(4'b0111));
        tick();
        ap_start = '0;

        // Ingress fill, overflow, full with simultaneous push/pop on ch0
        for (int i = 0; i < 21; i++) begin
            din[0 +: PW] = {tbl[i].v, tbl[i].pl};
            rx_ready[0]  = tbl[i].rdy;
            @(negedge clk_400);
            chk("tbl_rx_valid", 0, 64'(rx_valid[0]), 64'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) chk("tbl_rx_data", 0, 64'(rx_data[0 +: DW]), 64'(tbl[i].exp_rd));
            chk("tbl_drop_cnt", 0, 64'(drop_cnt[0 +: CW]), drop_exp(tbl[i].exp_drop));
            eval_edge();
        end
        clear_inputs();

        // Egress resend on ch1
        ap_start = 4'b0111;
        tx_valid[1] = 1'b1;
        tx_data[DW +: DW] = 48'h55;
        tick();
        chk("egress_first", 1, 64'(dout[PW +: PW]), 64'({1'b1, 48'h55}));
        tx_valid[1] = 1'b0;
        resend[1]   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_400);
            chk("hold_tx_ready", 1, 64'(tx_ready[1]), 64'd0);
            chk("hold_dout", 1, 64'(dout[PW +: PW]), 64'({1'b1, 48'h55}));
            eval_edge();
        end
        resend[1]   = 1'b0;
        tx_valid[1] = 1'b1;
        tx_data[DW +: DW] = 48'h66;
        tick();
        chk("after_resend", 1, 64'(dout[PW +: PW]), 64'({1'b1, 48'h66}));
        tx_valid[1] = 1'b0;
        tick();

        // Masked ch3 drains and counts
        for (int i = 0; i < 5; i++) begin
            din[3*PW +: PW] = {1'b1, 48'(i + 1)};
            ap_start[3] = 1'b1;
            tx_valid[3] = 1'b1;
            rx_ready[3] = 1'b1;
            tick();
        end
        clear_inputs();
        chk("masked_drop_cnt", 3, 64'(drop_cnt[3*CW +: CW]), DROP_EN ? 64'd5 : 64'd0);
        chk("masked_dout", 3, 64'(dout[3*PW +: PW]), 64'd0);

        // Reset while ch1 holds a packet
        ap_start = 4'b0111;
        tx_valid[1] = 1'b1;
        tx_data[DW +: DW] = 48'h77;
        tick();
        tx_valid[1] = 1'b0;
        resend[1]   = 1'b1;
        tick();
        chk("pre_reset_hold", 1, 64'(dout[PW +: PW]), 64'({1'b1, 48'h77}));
        reset_400 = 1'b0;
        #1;
        chk("async_rst_dout", 1, 64'(dout[PW +: PW]), 64'd0);
        chk("async_rst_tx_ready", 0, 64'(tx_ready), 64'd0);
        model_reset();
        @(negedge clk_400);
        reset_400 = 1'b1;
        @(posedge clk_400);
        #1;
        tick();
        tick();
        chk("idle_after_reset", 1, 64'(dout[PW +: PW]), 64'd0);
        clear_inputs();

        // Randomized traffic on all channels
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NL; c++) begin
                din[c*PW +: PW]   = {($urandom_range(0, 1) == 1), DW'({$urandom(), $urandom()})};
                tx_data[c*DW +: DW] = DW'({$urandom(), $urandom()});
            end
            rx_ready = NL'($urandom());
            tx_valid = NL'($urandom());
            ap_start = NL'($urandom() | $urandom());
            resend   = NL'($urandom() & $urandom());
            tick();
        end
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
